tinyml_frame_ctrl: RTL and testbench

Frame-level sequencer for the TinyML preprocessing pipeline (nearest-neighbour downscale → rgb2gray → 4-pixel pack). On a software start request it flushes the pipeline and waits for the camera start-of-frame. It then forwards exactly one frame of pixel-valids into the pipeline and counts the packed output words. Finally it reports done or error to the CPU-side register/interrupt logic. It sits between the camera pixel stream and the pipeline's `pixel_in_valid` input. The pixel data bus bypasses this block; only valid strobes are gated.

---
 rtl/tinyml_frame_ctrl_pkg.sv | 29 ++
 rtl/tinyml_frame_ctrl_if.sv | 19 +
 rtl/tinyml_timeout_cnt.sv | 22 ++
 rtl/tinyml_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_tinyml_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyml_frame_ctrl_pkg.sv
// Shared types and sizing helpers for the TinyML frame controller.
// Default geometry matches the 540x540 camera feeding a 96x96 packed output.
package tinyml_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WAIT_SOF,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int DEF_FRAME_WIDTH   = 540;
    localparam int DEF_FRAME_HEIGHT  = 540;
    localparam int DEF_OUT_WORDS     = 2304;
    localparam int DEF_FLUSH_CYCLES  = 4;
    localparam int DEF_DRAIN_TIMEOUT = 1024;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tinyml_frame_ctrl_if.sv
// Camera-side strobes and pipeline-side control between the sequencer and the pipeline.
// Pixel data never passes through here; only valids and the pipeline reset.
interface tinyml_frame_ctrl_if;
    logic cam_sof;
    logic cam_pixel_valid;
    logic pipe_out_valid;
    logic pipe_rst;
    logic pipe_pixel_valid;

    modport master (
        input  cam_sof, cam_pixel_valid, pipe_out_valid,
        output pipe_rst, pipe_pixel_valid
    );

    modport slave (
        output cam_sof, cam_pixel_valid, pipe_out_valid,
        input  pipe_rst, pipe_pixel_valid
    );
endinterface

// File: rtl/tinyml_timeout_cnt.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared by the flush hold time and the drain watchdog.
module tinyml_timeout_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)                   cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (en && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/tinyml_frame_ctrl.sv
// Frame sequencer: flushes the pipeline, gates exactly one frame of pixel
// valids into it, counts packed output words and reports done/error.
module tinyml_frame_ctrl
    import tinyml_ctrl_pkg::*;
#(
    parameter int FRAME_WIDTH   = DEF_FRAME_WIDTH,
    parameter int FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
    parameter int OUT_WORDS     = DEF_OUT_WORDS,
    parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         abort,
    tinyml_frame_ctrl_if.master                          bus,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         error,
    output logic [$clog2(FRAME_WIDTH*FRAME_HEIGHT+1)-1:0] in_pix_cnt,
    output logic [$clog2(OUT_WORDS+2)-1:0]               out_word_cnt
);
    localparam int IN_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int PIX_W     = $clog2(IN_PIXELS + 1);
    localparam int WRD_W     = $clog2(OUT_WORDS + 2);
    localparam int TMR_W     = cnt_w(max_int(FLUSH_CYCLES, DRAIN_TIMEOUT));

    state_e             state, state_nxt;
    logic               accept, fwd, err_set, pix_last;
    logic               tmr_load, tmr_en, tmr_expired;
    logic [TMR_W-1:0]   tmr_val;
    logic               wrd_en;
    logic [WRD_W-1:0]   wrd_nxt;

    tinyml_timeout_cnt #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    assign tmr_en   = (state == ST_FLUSH) || (state == ST_DRAIN);
    assign accept   = (state == ST_IDLE) && start;
    assign pix_last = (in_pix_cnt == PIX_W'(IN_PIXELS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        err_set   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                // Flush length counts down to zero, so load one less than the hold time.
                if (start) begin
                    state_nxt = ST_FLUSH;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tmr_expired) begin
                    state_nxt = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (abort) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (bus.cam_pixel_valid && bus.cam_sof) begin
                    fwd       = 1'b1;
                    state_nxt = ST_RUN;
                    if (pix_last) begin
                        state_nxt = ST_DRAIN;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(DRAIN_TIMEOUT - 1);
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (bus.cam_pixel_valid) begin
                    if (bus.cam_sof) begin
                        err_set   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        fwd = 1'b1;
                        if (pix_last) begin
                            state_nxt = ST_DRAIN;
                            tmr_load  = 1'b1;
                            tmr_val   = TMR_W'(DRAIN_TIMEOUT - 1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (out_word_cnt == WRD_W'(OUT_WORDS)) begin
                    state_nxt = ST_DONE;
                end else if (tmr_expired) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wrd_en  = ((state == ST_RUN) || (state == ST_DRAIN)) && bus.pipe_out_valid &&
                  (out_word_cnt != WRD_W'(OUT_WORDS + 1));
        wrd_nxt = wrd_en ? out_word_cnt + 1'b1 : out_word_cnt;
    end

    // The final word-count verdict is folded in on entry to DONE so it lines up with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_pix_cnt   <= '0;
            out_word_cnt <= '0;
            error        <= 1'b0;
        end else if (accept) begin
            in_pix_cnt   <= '0;
            out_word_cnt <= '0;
            error        <= 1'b0;
        end else begin
            if (fwd) in_pix_cnt <= in_pix_cnt + 1'b1;
            out_word_cnt <= wrd_nxt;
            if (err_set || (wrd_nxt == WRD_W'(OUT_WORDS + 1)) ||
                ((state_nxt == ST_DONE) && (wrd_nxt != WRD_W'(OUT_WORDS))))
                error <= 1'b1;
        end
    end

    assign busy                 = (state != ST_IDLE);
    assign done                 = (state == ST_DONE);
    assign bus.pipe_rst         = (state == ST_FLUSH);
    assign bus.pipe_pixel_valid = fwd && !rst;
endmodule

// File: tb/tb_tinyml_frame_ctrl.sv
// Randomised frame-level bench: the stimulus predicts each frame's outcome
// into a scoreboard and an independent monitor checks it when done appears.
module tb_tinyml_frame_ctrl;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int OW   = 2;
    localparam int FC   = 4;
    localparam int DT   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, error;
    logic [5:0] in_pix_cnt;
    logic [1:0] out_word_cnt;

    tinyml_frame_ctrl_if bus ();

    tinyml_frame_ctrl #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .OUT_WORDS     (OW),
        .FLUSH_CYCLES  (FC),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .in_pix_cnt   (in_pix_cnt),
        .out_word_cnt (out_word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic err;
        int   pix;
        int   words;
        int   done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pulse counting, flush-length and per-frame result checks.
    int fwd_cnt = 0;
    int rst_run = 0;
    bit prev_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            fwd_cnt   = 0;
            rst_run   = 0;
            prev_done = 0;
        end else begin
            if (bus.pipe_pixel_valid) fwd_cnt++;
            if (bus.pipe_rst) rst_run++;
            else if (rst_run != 0) begin
                chk("flush_len", rst_run, FC);
                rst_run = 0;
            end
            if (prev_done) chk("idle_after_done", {30'd0, done, busy}, 0);
            if (done) begin
                if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("done_error", error, e.err);
                    chk("in_pix_cnt", in_pix_cnt, e.pix);
                    chk("out_word_cnt", out_word_cnt, e.words);
                    chk("fwd_pulses", fwd_cnt, e.pix);
                    chk("done_cycle", cyc, e.done_cyc);
                end
                fwd_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input bit s, input bit a, input bit w);
        bus.cam_pixel_valid = 1'b1;
        bus.cam_sof         = s;
        abort               = a;
        bus.pipe_out_valid  = w;
        step();
        bus.cam_pixel_valid = 1'b0;
        bus.cam_sof         = 1'b0;
        abort               = 1'b0;
        bus.pipe_out_valid  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_pipe_rst"}, bus.pipe_rst, 0);
        chk({tag, "_pipe_pv"}, bus.pipe_pixel_valid, 0);
        chk({tag, "_pix"}, in_pix_cnt, 0);
        chk({tag, "_words"}, out_word_cnt, 0);
    endtask

    // n_words: 1 = one word mid-frame, 2 = nominal (mid + drain), 3 = four words (overflow).
    task automatic run_frame(input int abort_at, input int prem_at, input int n_words,
                             input bit early_sof, input bit start_busy, input bit abort_with_start);
        int   set_cyc, last_pix, last_word, nw, npix, extra;
        bit   ended;
        exp_t e;
        set_cyc = 0; last_pix = 0; last_word = 0; nw = 0; npix = 0; ended = 0;
        start = 1'b1;
        abort = abort_with_start;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err_clr", error, 0);
        extra = $urandom_range(0, 3);
        for (int k = 0; k < FC + extra; k++) begin
            bus.cam_pixel_valid = (early_sof && k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.cam_sof         = (early_sof && k == 1);
            step();
        end
        bus.cam_pixel_valid = 1'b0;
        bus.cam_sof         = 1'b0;
        for (int i = 1; i <= NPIX && !ended; i++) begin
            bit w;
            w = (n_words >= 1 && i == 16) || (n_words == 3 && (i == 8 || i == 24 || i == 28));
            if (i == abort_at) begin
                set_cyc = cyc;
                drive_pix(i == 1, 1'b1, 1'b0);
                ended = 1;
            end else if (i == prem_at) begin
                set_cyc = cyc;
                drive_pix(1'b1, 1'b0, 1'b0);
                ended = 1;
            end else begin
                last_pix = cyc;
                drive_pix(i == 1, 1'b0, w);
                npix++;
                if (w) nw++;
                if (start_busy && i == 5) begin
                    start = 1'b1;
                    step();
                    start = 1'b0;
                end
                if (i != NPIX) repeat ($urandom_range(0, 2)) step();
            end
        end
        if (ended) begin
            e.err      = 1'b1;
            e.pix      = npix;
            e.words    = (nw > OW + 1) ? OW + 1 : nw;
            e.done_cyc = set_cyc + 1;
        end else begin
            if (n_words == 2) begin
                step();
                bus.pipe_out_valid = 1'b1;
                last_word = cyc;
                step();
                bus.pipe_out_valid = 1'b0;
                nw++;
            end
            e.pix      = npix;
            e.words    = (nw > OW + 1) ? OW + 1 : nw;
            e.err      = (nw != OW);
            e.done_cyc = (nw == OW) ? (((last_word > last_pix) ? last_word : last_pix) + 2)
                                    : (last_pix + DT + 1);
        end
        sb_q.push_back(e);
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("done_seen", sb_q.size(), 0);
        sb_q.delete();
        repeat (2) step();
    endtask

    initial begin
        int ab, pr;
        bus.cam_sof         = 1'b0;
        bus.cam_pixel_valid = 1'b0;
        bus.pipe_out_valid  = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        rst = 1'b0;
        step();

        run_frame(0, 0, 2, 1'b0, 1'b0, 1'b0);   // nominal
        run_frame(0, 0, 2, 1'b1, 1'b0, 1'b0);   // SOF during flush is dropped
        run_frame(0, 0, 1, 1'b0, 1'b0, 1'b0);   // drain timeout
        run_frame(0, 20, 2, 1'b0, 1'b0, 1'b0);  // premature SOF
        run_frame(10, 0, 2, 1'b0, 1'b1, 1'b0);  // abort + start while busy
        chk("err_sticky", error, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_err", error, 1);
        run_frame(0, 0, 2, 1'b0, 1'b0, 1'b1);   // start+abort together: start wins
        run_frame(0, 0, 3, 1'b0, 1'b0, 1'b0);   // too many words, saturation

        // Reset in the middle of RUN.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (FC) step();
        for (int i = 1; i <= 8; i++) drive_pix(i == 1, 1'b0, 1'b0);
        chk("pre_rst_pix", in_pix_cnt, 8);
        rst = 1'b1;
        step();
        chk_idle("mid_rst");
        rst = 1'b0;
        step();
        run_frame(0, 0, 2, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NPIX)) : 0;
            pr = (ab == 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(2, NPIX)) : 0;
            run_frame(ab, pr, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
